// File: rtl/clock_switch_ctrl.sv
`timescale 1ns/1ps
// Handshake controller for a glitch-free clock mux: DROP old source, RISE new, SETTLE, commit.
// Build macro CLKSW_TIMEOUT_EN adds a per-phase handshake timeout with an err pulse.
module clock_switch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic a_active,
    input  logic b_active,
    output logic sel_clkb,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [2:0] {IDLE, DROP, RISE, SETTLE, FIN} state_t;

    localparam logic [9:0] SETTLE_LOAD = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] TO_LIM      = 10'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
    logic                   a_s, b_s;
    state_t                 state_q, state_d;
    logic [9:0]             cnt_q, cnt_d, cnt_inc;
    logic                   sel_q, sel_d, cur_q, cur_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   old_active, new_active, timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign a_sync_d[gi] = a_active;
                assign b_sync_d[gi] = b_active;
            end else begin : g_tail
                assign a_sync_d[gi] = a_sync_q[gi-1];
                assign b_sync_d[gi] = b_sync_q[gi-1];
            end
        end
    endgenerate

    assign a_s        = a_sync_q[SYNC_STAGES-1];
    assign b_s        = b_sync_q[SYNC_STAGES-1];
    assign old_active = cur_q ? b_s : a_s;
    assign new_active = sel_q ? b_s : a_s;
    assign cnt_inc    = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;

`ifdef CLKSW_TIMEOUT_EN
    assign timeout_hit = (cnt_q >= (TO_LIM - 10'd1));
`else
    logic unused_to_lim;
    assign timeout_hit   = 1'b0;
    assign unused_to_lim = ^TO_LIM;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            cur_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_sync_q <= a_sync_d;
            b_sync_q <= b_sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            cur_q    <= cur_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_sel == cur_q) begin
                        state_d = FIN;
                    end else begin
                        sel_d   = req_sel;
                        cnt_d   = '0;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                // Overlap (both sources on) keeps old_active high, so we keep waiting.
                if (!old_active) begin
                    cnt_d   = '0;
                    state_d = RISE;
                end else if (timeout_hit) begin
                    sel_d   = cur_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RISE: begin
                if (new_active) begin
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end else if (timeout_hit) begin
                    sel_d   = cur_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SETTLE: begin
                if (cnt_q == 10'd0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // done and cur_sel are registered on entry to FIN so both are visible during FIN.
        if (state_d == FIN) begin
            done_d = 1'b1;
            cur_d  = sel_d;
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        busy      = (state_q != IDLE);
    end

    assign sel_clkb = sel_q;
    assign cur_sel  = cur_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for clock_switch_ctrl: directed scenarios plus randomized switches
// checked against a cycle-level behavioural model of the handshake rules.
module tb_clock_switch_ctrl;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int TMO    = 8;
`ifdef CLKSW_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel = 1'b0;
    logic a_active = 1'b0;
    logic b_active = 1'b0;
    logic req_ready, sel_clkb, cur_sel, busy, done, err;
    logic [5:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 wait old off, 2 wait new on, 3 settling, 4 committing.
    int   m_phase = 0;
    int   m_wait = 0;
    int   m_settled = 0;
    logic m_sel = 1'b0, m_cur = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic m_as = 1'b0, m_bs = 1'b0;
    logic qa[$];
    logic qb[$];

    clock_switch_ctrl #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .a_active(a_active), .b_active(b_active), .sel_clkb(sel_clkb), .cur_sel(cur_sel),
        .busy(busy), .done(done), .err(err)
    );

    assign dut_vec = {sel_clkb, cur_sel, busy, done, err, req_ready};

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] exp_vec();
        return {m_sel, m_cur, (m_phase != 0), m_done, m_err, (m_phase == 0) && !rst};
    endfunction

    task automatic model_edge();
        logic as_now = m_as;
        logic bs_now = m_bs;
        if (rst) begin
            m_phase = 0; m_wait = 0; m_settled = 0;
            m_sel = 1'b0; m_cur = 1'b0; m_done = 1'b0; m_err = 1'b0;
            qa = {}; qb = {};
            repeat (SYNC) begin qa.push_back(1'b0); qb.push_back(1'b0); end
            m_as = 1'b0; m_bs = 1'b0;
            return;
        end
        m_done = 1'b0;
        m_err  = 1'b0;
        case (m_phase)
            0: if (req_valid) begin
                if (req_sel == m_cur) begin m_phase = 4; m_done = 1'b1; end
                else begin m_sel = req_sel; m_phase = 1; m_wait = 0; end
            end
            1: if (!(m_cur ? bs_now : as_now)) begin m_phase = 2; m_wait = 0; end
               else if (TO_EN && m_wait + 1 >= TMO) begin m_err = 1'b1; m_sel = m_cur; m_phase = 0; end
               else m_wait++;
            2: if (m_sel ? bs_now : as_now) begin m_phase = 3; m_settled = 0; end
               else if (TO_EN && m_wait + 1 >= TMO) begin m_err = 1'b1; m_sel = m_cur; m_phase = 0; end
               else m_wait++;
            3: begin
                m_settled++;
                if (m_settled == SETTLE) begin m_phase = 4; m_done = 1'b1; m_cur = m_sel; end
            end
            default: m_phase = 0;
        endcase
        qa.push_back(a_active);
        qb.push_back(b_active);
        m_as = qa[qa.size() - SYNC];
        m_bs = qb[qb.size() - SYNC];
        void'(qa.pop_front());
        void'(qb.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_active = 1'($urandom_range(0, 1));
        b_active = 1'($urandom_range(0, 1));
        req_valid = 1'($urandom_range(0, 1));
        req_sel = 1'($urandom_range(0, 1));
        repeat (3) tick();
        checks++;
        if (dut_vec !== 6'b000000) begin
            errors++; $display("FAIL reset_state got %b want %b", dut_vec, 6'b000000);
        end
        rst = 1'b0; req_valid = 1'b0; a_active = 1'b1; b_active = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after got %b want 1", req_ready);
        end
        repeat (SYNC + 1) tick();
    endtask

    task automatic test_normal_switch();
        int done_at = -1;
        req_valid = 1'b1; req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (sel_clkb !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL normal_sel_rise got sel=%b busy=%b want 1/1", sel_clkb, busy);
        end
        repeat (3) tick();
        a_active = 1'b0;
        repeat (3) tick();
        b_active = 1'b1;
        for (int i = 7; i <= 40 && done_at < 0; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL normal_model_cyc%0d got %b want %b", i, dut_vec, exp_vec());
            end
            if (done === 1'b1) done_at = i;
        end
        checks++;
        if (done_at != 13) begin
            errors++; $display("FAIL normal_done_cycle got %0d want 13", done_at);
        end
        checks++;
        if (cur_sel !== 1'b1) begin
            errors++; $display("FAIL normal_cur_at_done got %b want 1", cur_sel);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL normal_busy_after got busy=%b done=%b want 0/0", busy, done);
        end
        $display("txn normal_switch done_at=%0d cur_sel=%b", done_at, cur_sel);
    endtask

    task automatic test_same_source();
        rst = 1'b1; a_active = 1'b1; b_active = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        req_valid = 1'b1; req_sel = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL same_done_next got %b want 1", done);
        end
        checks++;
        if (sel_clkb !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL same_sel_err got sel=%b err=%b want 0/0", sel_clkb, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL same_after got done=%b busy=%b ready=%b want 0/0/1", done, busy, req_ready);
        end
        $display("txn same_source sel_clkb=%b", sel_clkb);
    endtask

    task automatic test_busy_request();
        int ndone = 0;
        int busy_bad = 0;
        req_valid = 1'b1; req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        a_active = 1'b0;
        for (int i = 0; i < 20 && m_phase != 2; i++) tick();
        req_valid = 1'b1; req_sel = 1'b0;
        repeat (3) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
        end
        req_valid = 1'b0;
        b_active = 1'b1;
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL busy_ignore_cycles got %0d bad want 0", busy_bad);
        end
        repeat (25) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL busy_done_count got %0d want 1", ndone);
        end
        checks++;
        if (cur_sel !== 1'b1 || sel_clkb !== 1'b1) begin
            errors++; $display("FAIL busy_final_sel got cur=%b sel=%b want 1/1", cur_sel, sel_clkb);
        end
        $display("txn busy_request dones=%0d cur_sel=%b", ndone, cur_sel);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        req_valid = 1'b1; req_sel = 1'b0;
        tick();
        req_valid = 1'b0;
        b_active = 1'b0; a_active = 1'b1;
        for (int i = 0; i < 30 && m_phase != 3; i++) tick();
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_settle got busy=%b done=%b want 1/0", busy, done);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec !== 6'b000000) begin
            errors++; $display("FAIL rstmid_state got %b want %b", dut_vec, 6'b000000);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got %b want 1", req_ready);
        end
        repeat (8) begin
            tick();
            if (done === 1'b1 || err === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || cur_sel !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_pulse got pulses=%0d cur=%b want 0/0", ndone, cur_sel);
        end
        $display("txn reset_mid cur_sel=%b", cur_sel);
    endtask

`ifdef CLKSW_TIMEOUT_EN
    task automatic test_timeout();
        int err_at = -1;
        int ndone = 0;
        req_valid = 1'b1; req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 30 && err_at < 0; i++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (err === 1'b1) err_at = i;
        end
        checks++;
        if (err_at != TMO) begin
            errors++; $display("FAIL timeout_err_cycle got %0d want %0d", err_at, TMO);
        end
        checks++;
        if (sel_clkb !== 1'b0 || cur_sel !== 1'b0 || ndone != 0) begin
            errors++; $display("FAIL timeout_restore got sel=%b cur=%b dones=%0d want 0/0/0", sel_clkb, cur_sel, ndone);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_after got err=%b busy=%b want 0/0", err, busy);
        end
        $display("txn timeout err_at=%0d", err_at);
    endtask
`else
    task automatic test_hang();
        int bad = 0;
        req_valid = 1'b1; req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5000) begin
            tick();
            if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hang_in_drop got %0d bad cycles want 0", bad);
        end
        checks++;
        if (sel_clkb !== 1'b1 || cur_sel !== 1'b0) begin
            errors++; $display("FAIL hang_sel got sel=%b cur=%b want 1/0", sel_clkb, cur_sel);
        end
        $display("txn hang bad_cycles=%0d", bad);
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic tgt = 1'($urandom_range(0, 1));
            logic old = m_cur;
            bit   sw  = (tgt != m_cur);
            int   d1  = $urandom_range(1, 6);
            int   d2  = $urandom_range(0, 6);
            bit   fin = 1'b0;
            int   ncyc = 0;
            string res = "none";
            for (int cyc = 0; cyc <= 300 && !fin; cyc++) begin
                if (cyc == 0) begin
                    req_valid = 1'b1; req_sel = tgt;
                end else begin
                    if (sw && cyc == d1) begin
                        if (old) b_active = 1'b0; else a_active = 1'b0;
                    end
                    if (sw && cyc == d1 + d2) begin
                        if (tgt) b_active = 1'b1; else a_active = 1'b1;
                    end
                    req_valid = (m_phase != 0) && ($urandom_range(0, 3) == 0);
                    req_sel = 1'($urandom_range(0, 1));
                end
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL rand_t%0d_c%0d got %b want %b", t, cyc, dut_vec, exp_vec());
                end
                ncyc = cyc;
                if (m_done) begin fin = 1'b1; res = "done"; end
                if (m_err) begin fin = 1'b1; res = "err"; end
            end
            req_valid = 1'b0;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL rand_t%0d_tail got %b want %b", t, dut_vec, exp_vec());
            end
            $display("txn rand %0d tgt=%0d switch=%0d result=%s cycles=%0d", t, tgt, sw, res, ncyc);
        end
    endtask

    initial begin
        test_reset();
        test_normal_switch();
        test_same_source();
        test_busy_request();
        test_reset_mid();
`ifdef CLKSW_TIMEOUT_EN
        test_timeout();
`else
        test_hang();
`endif
        rst = 1'b1; a_active = 1'b1; b_active = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
